// File: rtl/eeprom_pkg.sv
// Shared constants and state encodings for the EEPROM request arbiter.
package eeprom_pkg;

    localparam int ADDR_W          = 11;
    localparam int DATA_W          = 8;
    localparam int TIMER_W         = 12;
    localparam int TIMEOUT_DEFAULT = 4095;

    // One-hot controller states
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_ISSUE   = 4'b0010,
        ST_WAIT    = 4'b0100,
        ST_RECOVER = 4'b1000
    } state_t;

endpackage

// File: rtl/eeprom_timeout_cnt.sv
// Saturating WAIT-state timer with synchronous clear and count enable.
// at_limit is high when the counter already sits at LIMIT, or when this
// enabled cycle is the one that takes it to LIMIT, so the caller can act on
// the same edge the limit is reached.
module eeprom_timeout_cnt
    import eeprom_pkg::*;
#(
    parameter int               W     = TIMER_W,
    parameter logic [W-1:0]     LIMIT = W'(TIMEOUT_DEFAULT)
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic at_limit
);

    localparam logic [W-1:0] LIMIT_M1 = LIMIT - 1'b1;

    logic [W-1:0] count;

    // Count enabled cycles, holding at LIMIT instead of wrapping
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Limit flag includes the cycle whose increment reaches LIMIT
    always_comb begin
        at_limit = (count == LIMIT) || (enable && (count == LIMIT_M1));
    end

endmodule

// File: rtl/eeprom_arb.sv
// Two-requester round-robin arbiter in front of a serial EEPROM engine.
// A winner's request is latched in IDLE, a start pulse is issued, then the
// controller waits for the engine ACK or a timeout before recovering.
module eeprom_arb
    import eeprom_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              DONE0,
    output logic              DONE1,
    output logic              ERR0,
    output logic              ERR1,
    output logic [DATA_W-1:0] RDATA0,
    output logic [DATA_W-1:0] RDATA1,
    output logic              BUSY,
    output logic              E_WR,
    output logic              E_RD,
    output logic [ADDR_W-1:0] E_ADDR,
    inout  wire  [DATA_W-1:0] E_DATA,
    input  logic              E_ACK,
    output logic              E_ABORT
);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic                abort_q, abort_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                winner;
    logic                timer_clear, timer_en, timer_at_limit;
    logic                drive_data;

    eeprom_timeout_cnt #(
        .W     (TIMER_W),
        .LIMIT (TIMER_W'(TIMEOUT))
    ) u_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (timer_clear),
        .enable   (timer_en),
        .at_limit (timer_at_limit)
    );

    // State, latched request and registered pulse/grant outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            abort_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            abort_q  <= abort_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state, arbitration and completion decisions
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        abort_d     = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        winner      = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    winner  = (REQ0 && REQ1) ? ~last_q : REQ1;
                    last_d  = winner;
                    owner_d = winner;
                    we_d    = winner ? WE1    : WE0;
                    addr_d  = winner ? ADDR1  : ADDR0;
                    wdata_d = winner ? WDATA1 : WDATA0;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_clear = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                if (E_ACK) begin
                    if (owner_q) begin
                        done1_d = 1'b1;
                        if (!we_q) rdata1_d = E_DATA;
                    end else begin
                        done0_d = 1'b1;
                        if (!we_q) rdata0_d = E_DATA;
                    end
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    state_d = ST_RECOVER;
                end else if (timer_at_limit) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    err0_d  = ~owner_q;
                    err1_d  = owner_q;
                    abort_d = 1'b1;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (!E_ACK) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Engine strobes and data bus enable decoded from the current state
    always_comb begin
        E_WR       = (state_q == ST_ISSUE) && we_q;
        E_RD       = (state_q == ST_ISSUE) && !we_q;
        drive_data = we_q && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));
        BUSY       = (state_q != ST_IDLE);
    end

    assign E_DATA  = drive_data ? wdata_q : {DATA_W{1'bz}};
    assign E_ADDR  = addr_q;
    assign GNT0    = gnt0_q;
    assign GNT1    = gnt1_q;
    assign DONE0   = done0_q;
    assign DONE1   = done1_q;
    assign ERR0    = err0_q;
    assign ERR1    = err1_q;
    assign E_ABORT = abort_q;
    assign RDATA0  = rdata0_q;
    assign RDATA1  = rdata1_q;

endmodule
